// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 message-schedule widths, word type, FSM states and K round constants
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int BLOCK_WORDS = 16;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic {LOAD, STREAM} state_e;
  localparam word_t K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
endpackage

// File: rtl/sha256_sched_sigma.sv
// sha256_sched_sigma: combinational small sigma0 (of x0) and sigma1 (of x1) schedule functions
module sha256_sched_sigma
  import sha256_pkg::*;
(
  input  word_t x0,
  input  word_t x1,
  output word_t s0,
  output word_t s1
);
  assign s0 = {x0[6:0], x0[31:7]} ^ {x0[17:0], x0[31:18]} ^ (x0 >> 3);
  assign s1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ (x1 >> 10);
endmodule

// File: rtl/sha256_message_scheduler.sv
// sha256_message_scheduler: loads W0..W15, streams W0..W63 from a sliding window; SHA256_SCHED_KADD_EN emits W_t+K_t
module sha256_message_scheduler #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] w_out,
  output logic [5:0]        out_round,
  output logic              out_last,
  output logic              busy
);
  import sha256_pkg::*;
  state_e state_q, state_d;
  word_t win_q [BLOCK_WORDS];
  word_t win_d [BLOCK_WORDS];
  logic [3:0] lcnt_q, lcnt_d;
  logic [5:0] t_q, t_d;
  word_t s0, s1, w_raw;
  sha256_sched_sigma u_sigma (.x0(win_q[1]), .x1(win_q[14]), .s0(s0), .s1(s1));
`ifdef SHA256_SCHED_KADD_EN
  assign w_raw = win_q[0] + K[t_q];
`else
  assign w_raw = win_q[0];
`endif
  assign busy = state_q == STREAM;
  assign out_valid = busy;
  assign in_ready = !busy;
  assign w_out = busy ? w_raw : '0;
  assign out_round = t_q;
  assign out_last = busy && t_q == 6'(ROUNDS - 1);
  always_comb begin
    state_d = state_q;
    lcnt_d = lcnt_q;
    t_d = t_q;
    win_d = win_q;
    if (flush) begin
      state_d = LOAD;
      lcnt_d = '0;
      t_d = '0;
    end else if (state_q == LOAD) begin
      if (in_valid) begin
        win_d[lcnt_q] = in_word;
        lcnt_d = lcnt_q + 4'd1;
        state_d = lcnt_q == 4'd15 ? STREAM : LOAD;
        t_d = '0;
      end
    end else if (out_ready) begin
      // shift down and append W[t+16]; expansion keeps running past t=48, surplus is dropped
      for (int i = 0; i < BLOCK_WORDS - 1; i++) win_d[i] = win_q[i+1];
      win_d[BLOCK_WORDS-1] = s1 + win_q[9] + s0 + win_q[0];
      t_d = t_q + 6'd1;
      state_d = t_q == 6'(ROUNDS - 1) ? LOAD : STREAM;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      lcnt_q <= '0;
      t_q <= '0;
      win_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      lcnt_q <= lcnt_d;
      t_q <= t_d;
      win_q <= win_d;
    end
endmodule
